// File: rtl/openframe_gpio_cfg.sv
// Per-pad GPIO configuration: shadow/active word banks with a hold-protected apply sequence.
// Optional shadow readback on cfg_rdata is enabled by defining OPENFRAME_CFG_READBACK_EN.
module openframe_gpio_cfg #(
  parameter int          NUM_PADS  = 44,
  parameter int          PAD_AW    = 6,
  parameter logic [12:0] RESET_CFG = 13'h0401
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                cfg_we,
  input  logic [PAD_AW-1:0]   cfg_addr,
  input  logic [12:0]         cfg_wdata,
  output logic [12:0]         cfg_rdata,
  input  logic                cfg_apply,
  output logic                cfg_busy,
  output logic                cfg_done,
  output logic                cfg_err,
  input  logic [NUM_PADS-1:0] core_out,
  input  logic [NUM_PADS-1:0] core_oeb,
  output logic [NUM_PADS-1:0] gpio_out,
  output logic [NUM_PADS-1:0] gpio_oeb,
  output logic [NUM_PADS-1:0] gpio_inp_dis,
  output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
  output logic [NUM_PADS-1:0] gpio_vtrip_sel,
  output logic [NUM_PADS-1:0] gpio_slow_sel,
  output logic [NUM_PADS-1:0] gpio_holdover,
  output logic [NUM_PADS-1:0] gpio_analog_en,
  output logic [NUM_PADS-1:0] gpio_analog_sel,
  output logic [NUM_PADS-1:0] gpio_analog_pol,
  output logic [NUM_PADS-1:0] gpio_dm2,
  output logic [NUM_PADS-1:0] gpio_dm1,
  output logic [NUM_PADS-1:0] gpio_dm0
);

  typedef enum logic [2:0] {IDLE, HOLD, LOAD, RELEASE, DONE} state_t;

  localparam logic [PAD_AW-1:0] LAST_IDX = PAD_AW'(NUM_PADS - 1);

  state_t            state, state_next;
  logic [PAD_AW-1:0] idx, idx_next;
  logic [12:0]       shadow [NUM_PADS];
  logic [12:0]       active [NUM_PADS];
  logic              addr_ok;
  logic              wr_en;
  logic              hold_force;

  assign addr_ok    = (32'(cfg_addr) < 32'(NUM_PADS));
  assign wr_en      = cfg_we && !cfg_busy && addr_ok;
  assign cfg_busy   = (state == HOLD) || (state == LOAD) || (state == RELEASE);
  assign cfg_done   = (state == DONE);
  assign hold_force = (state == HOLD) || (state == LOAD);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_PADS; i++) shadow[i] <= RESET_CFG;
    end else if (wr_en) begin
      shadow[cfg_addr] <= cfg_wdata;
    end
  end

  // LOAD reads shadow after any same-cycle write from the apply cycle has landed
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_PADS; i++) active[i] <= RESET_CFG;
    end else if (state == LOAD) begin
      active[idx] <= shadow[idx];
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      idx     <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      cfg_err <= cfg_we && !cfg_busy && !addr_ok;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (cfg_apply) begin
          state_next = HOLD;
          idx_next   = '0;
        end
      end
      HOLD:    state_next = LOAD;
      LOAD:    state_next = RELEASE;
      RELEASE: begin
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          state_next = HOLD;
          idx_next   = idx + PAD_AW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign gpio_out = core_out;

  // Only the pad currently being swapped sees its holdover forced high
  always_comb begin
    for (int i = 0; i < NUM_PADS; i++) begin
      gpio_oeb[i]         = active[i][1] ? core_oeb[i] : active[i][0];
      gpio_inp_dis[i]     = active[i][2];
      gpio_ib_mode_sel[i] = active[i][3];
      gpio_vtrip_sel[i]   = active[i][4];
      gpio_slow_sel[i]    = active[i][5];
      gpio_holdover[i]    = active[i][6] | (hold_force && (idx == PAD_AW'(i)));
      gpio_analog_en[i]   = active[i][7];
      gpio_analog_sel[i]  = active[i][8];
      gpio_analog_pol[i]  = active[i][9];
      gpio_dm0[i]         = active[i][10];
      gpio_dm1[i]         = active[i][11];
      gpio_dm2[i]         = active[i][12];
    end
  end

`ifdef OPENFRAME_CFG_READBACK_EN
  always_comb begin
    cfg_rdata = '0;
    if (addr_ok) cfg_rdata = shadow[cfg_addr];
  end
`else
  assign cfg_rdata = '0;
`endif

endmodule

// File: tb/tb_openframe_gpio_cfg.sv
// Randomized scoreboard bench for openframe_gpio_cfg; a monitor checks every cfg_done/cfg_err pulse.
module tb_openframe_gpio_cfg;

  localparam int          N         = 44;
  localparam int          AW        = 6;
  localparam logic [12:0] RST       = 13'h0401;
  localparam int          APPLY_LEN = 3 * N + 1;

  typedef logic [N-1:0][12:0] wordsT;
  typedef struct {
    int    doneCycle;
    int    applyCycle;
    wordsT words;
  } doneExpT;

  logic          clock = 1'b0;
  logic          resetb = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [12:0]   cfg_wdata = '0;
  logic [12:0]   cfg_rdata;
  logic          cfg_apply = 1'b0;
  logic          cfg_busy, cfg_done, cfg_err;
  logic [N-1:0]  core_out = '0;
  logic [N-1:0]  core_oeb = '0;
  logic [N-1:0]  gpio_out, gpio_oeb, gpio_inp_dis, gpio_ib_mode_sel, gpio_vtrip_sel;
  logic [N-1:0]  gpio_slow_sel, gpio_holdover, gpio_analog_en, gpio_analog_sel;
  logic [N-1:0]  gpio_analog_pol, gpio_dm2, gpio_dm1, gpio_dm0;

  doneExpT     doneQ[$];
  int          errQ[$];
  logic [12:0] shadowModel [N];
  int          rem = 0;
  int          cycleCount = 0;
  int          checks = 0;
  int          failures = 0;

  openframe_gpio_cfg #(.NUM_PADS(N), .PAD_AW(AW), .RESET_CFG(RST)) dut (
    .clock(clock), .resetb(resetb), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_apply(cfg_apply),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .core_out(core_out), .core_oeb(core_oeb), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb),
    .gpio_inp_dis(gpio_inp_dis), .gpio_ib_mode_sel(gpio_ib_mode_sel),
    .gpio_vtrip_sel(gpio_vtrip_sel), .gpio_slow_sel(gpio_slow_sel),
    .gpio_holdover(gpio_holdover), .gpio_analog_en(gpio_analog_en),
    .gpio_analog_sel(gpio_analog_sel), .gpio_analog_pol(gpio_analog_pol),
    .gpio_dm2(gpio_dm2), .gpio_dm1(gpio_dm1), .gpio_dm0(gpio_dm0)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  function automatic logic [N-1:0] fieldOf(input wordsT w, input int b);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = w[i][b];
    return r;
  endfunction

  task automatic compareOutputs(input wordsT w);
    logic [N-1:0] expOeb;
    for (int i = 0; i < N; i++) expOeb[i] = w[i][1] ? core_oeb[i] : w[i][0];
    checkOutput("gpio_out", gpio_out, core_out);
    checkOutput("gpio_oeb", gpio_oeb, expOeb);
    checkOutput("gpio_inp_dis", gpio_inp_dis, fieldOf(w, 2));
    checkOutput("gpio_ib_mode_sel", gpio_ib_mode_sel, fieldOf(w, 3));
    checkOutput("gpio_vtrip_sel", gpio_vtrip_sel, fieldOf(w, 4));
    checkOutput("gpio_slow_sel", gpio_slow_sel, fieldOf(w, 5));
    checkOutput("gpio_holdover", gpio_holdover, fieldOf(w, 6));
    checkOutput("gpio_analog_en", gpio_analog_en, fieldOf(w, 7));
    checkOutput("gpio_analog_sel", gpio_analog_sel, fieldOf(w, 8));
    checkOutput("gpio_analog_pol", gpio_analog_pol, fieldOf(w, 9));
    checkOutput("gpio_dm0", gpio_dm0, fieldOf(w, 10));
    checkOutput("gpio_dm1", gpio_dm1, fieldOf(w, 11));
    checkOutput("gpio_dm2", gpio_dm2, fieldOf(w, 12));
  endtask

  task automatic resetModel();
    for (int i = 0; i < N; i++) shadowModel[i] = RST;
    rem = 0;
    doneQ.delete();
    errQ.delete();
  endtask

  task automatic checkResetState();
    logic [12:0] expRd;
`ifdef OPENFRAME_CFG_READBACK_EN
    expRd = RST;
`else
    expRd = '0;
`endif
    checkOutput("rst_gpio_oeb", gpio_oeb, {N{1'b1}});
    checkOutput("rst_gpio_dm0", gpio_dm0, {N{1'b1}});
    checkOutput("rst_gpio_dm1", gpio_dm1, '0);
    checkOutput("rst_gpio_dm2", gpio_dm2, '0);
    checkOutput("rst_gpio_holdover", gpio_holdover, '0);
    checkOutput("rst_gpio_inp_dis", gpio_inp_dis, '0);
    checkOutput("rst_gpio_analog_en", gpio_analog_en, '0);
    checkOutput("rst_cfg_busy", cfg_busy, 0);
    checkOutput("rst_cfg_done", cfg_done, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_rdata_addr5", cfg_rdata, expRd);
  endtask

  // Assert reset asynchronously mid-cycle, check the reset image, then release
  task automatic assertReset();
    resetb    = 1'b0;
    cfg_we    = 1'b0;
    cfg_apply = 1'b0;
    cfg_addr  = AW'(5);
    resetModel();
    #1;
    checkResetState();
    repeat (2) @(posedge clock);
    #1;
    resetb = 1'b1;
  endtask

  // Drive one cycle of inputs and advance the reference model by that cycle
  task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                               input logic [12:0] wdata, input logic apply);
    logic [12:0] expRd;
    logic        modelBusy, modelIdle;
    wordsT       w;
    doneExpT     e;
    @(posedge clock);
    #1;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = wdata;
    cfg_apply = apply;
    core_out  = N'({$urandom(), $urandom()});
    core_oeb  = N'({$urandom(), $urandom()});
    #1;
    modelBusy = (rem > 1);
    modelIdle = (rem == 0);
    checkOutput("cfg_busy", cfg_busy, modelBusy);
    expRd = '0;
`ifdef OPENFRAME_CFG_READBACK_EN
    if (int'(addr) < N) expRd = shadowModel[addr];
`endif
    checkOutput("cfg_rdata", cfg_rdata, expRd);
    if (we && !modelBusy) begin
      if (int'(addr) < N) shadowModel[addr] = wdata;
      else errQ.push_back(cycleCount + 1);
    end
    if (apply && modelIdle) begin
      for (int i = 0; i < N; i++) w[i] = shadowModel[i];
      e.doneCycle  = cycleCount + APPLY_LEN;
      e.applyCycle = cycleCount;
      e.words      = w;
      doneQ.push_back(e);
      rem = APPLY_LEN;
    end else if (rem > 0) begin
      rem--;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: pops expectations whenever the DUT raises cfg_done or cfg_err
  initial begin
    int      holdCount [N];
    int      firstHigh [N];
    int      maxOnes, busyCount, ones, badLen, badOrder, ec;
    doneExpT d;
    maxOnes = 0;
    busyCount = 0;
    for (int i = 0; i < N; i++) begin holdCount[i] = 0; firstHigh[i] = -1; end
    forever begin
      @(negedge clock);
      if (!resetb) begin
        maxOnes = 0;
        busyCount = 0;
        for (int i = 0; i < N; i++) begin holdCount[i] = 0; firstHigh[i] = -1; end
      end else begin
        ones = 0;
        for (int i = 0; i < N; i++) begin
          if (gpio_holdover[i]) begin
            ones++;
            holdCount[i]++;
            if (firstHigh[i] < 0) firstHigh[i] = cycleCount;
          end
        end
        if (ones > maxOnes) maxOnes = ones;
        if (cfg_busy) busyCount++;
        if (cfg_err) begin
          checkOutput("err_expected", errQ.size() != 0, 1);
          if (errQ.size() != 0) begin
            ec = errQ.pop_front();
            checkOutput("err_cycle", cycleCount, ec);
          end
        end
        if (cfg_done) begin
          checkOutput("done_expected", doneQ.size() != 0, 1);
          if (doneQ.size() != 0) begin
            d = doneQ.pop_front();
            checkOutput("done_cycle", cycleCount, d.doneCycle);
            checkOutput("busy_len", busyCount, 3 * N);
            badLen = 0;
            badOrder = 0;
            for (int i = 0; i < N; i++) begin
              if (holdCount[i] != 2) badLen++;
              if (firstHigh[i] != d.applyCycle + 1 + 3 * i) badOrder++;
            end
            checkOutput("holdover_len_bad_pads", badLen, 0);
            checkOutput("holdover_order_bad_pads", badOrder, 0);
            checkOutput("holdover_max_per_cycle", maxOnes, 1);
            compareOutputs(d.words);
          end
          maxOnes = 0;
          busyCount = 0;
          for (int i = 0; i < N; i++) begin holdCount[i] = 0; firstHigh[i] = -1; end
        end
      end
    end
  end

  initial begin
    resetModel();
    @(posedge clock);
    #1;
    assertReset();

    $display("[TB] pad 3 <- 13'h1802, then apply");
    applyStimulus(1'b1, AW'(3), 13'h1802, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1);
    idleCycles(APPLY_LEN + 3);

    $display("[TB] write to out-of-range pad 50");
    applyStimulus(1'b1, AW'(50), 13'h1fff, 1'b0);
    idleCycles(3);

    $display("[TB] write and second apply while busy");
    applyStimulus(1'b0, '0, '0, 1'b1);
    idleCycles(5);
    applyStimulus(1'b1, AW'(0), 13'h1abc, 1'b1);
    applyStimulus(1'b1, AW'(60), 13'h0123, 1'b0);
    idleCycles(APPLY_LEN + 3);

    $display("[TB] same-cycle write pad 0 <- 0 and apply");
    applyStimulus(1'b1, AW'(0), 13'h0000, 1'b1);
    idleCycles(APPLY_LEN + 3);
    checkOutput("pad0_oeb_after_apply", gpio_oeb[0], 0);
    checkOutput("pad0_dm0_after_apply", gpio_dm0[0], 0);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 1500; k++) begin
      applyStimulus($urandom_range(0, 99) < 30, AW'($urandom_range(0, 63)),
                    13'($urandom_range(0, 8191)) & ~13'h0040, $urandom_range(0, 99) < 4);
    end
    idleCycles(APPLY_LEN + 5);
    checkOutput("done_queue_drained", doneQ.size(), 0);
    checkOutput("err_queue_drained", errQ.size(), 0);

    $display("[TB] reset during RELEASE of pad 10");
    applyStimulus(1'b1, AW'(10), 13'h1c00, 1'b0);
    applyStimulus(1'b0, '0, '0, 1'b1);
    idleCycles(32);
    @(posedge clock);
    #1;
    checkOutput("pre_reset_pad10_dm2", gpio_dm2[10], 1);
    checkOutput("pre_reset_busy", cfg_busy, 1);
    assertReset();
    idleCycles(APPLY_LEN + 5);
    checkOutput("post_reset_pad10_dm2", gpio_dm2[10], 0);
    checkOutput("final_done_queue", doneQ.size(), 0);
    checkOutput("final_err_queue", errQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
